div_unit: RTL and testbench

//  Multi-cycle radix-2 restoring divider for DIV/DIVU, one quotient bit per cycle.

---
 rtl/div_unit.sv | 116 +++++++++++
 tb/tb_div_unit.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring divider for DIV/DIVU, one quotient bit per cycle.
//   clk          clock, all state on rising edge
//   rst          asynchronous active-low reset
//   signed_div_i 1 = signed (DIV), 0 = unsigned (DIVU)
//   opdata1_i    dividend, sampled when leaving FREE
//   opdata2_i    divisor, sampled when leaving FREE
//   start_i      request, held high until ready_o is seen
//   annul_i      cancel an in-flight division
//   result_o     {remainder, quotient}, registered, nonzero only in END
//   ready_o      result valid, registered, high only in END
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;
  state_t            state;
  logic [CW-1:0]     cnt;
  logic [WIDTH-1:0]  rem, dvd, dvs;
  logic              neg_q, neg_r;
  logic              neg1, neg2;
  logic [WIDTH-1:0]  mag1, mag2;
  logic [WIDTH:0]    shifted, trial;
  logic              qbit;
  logic [WIDTH-1:0]  rem_n, quo_n, rem_fix, quo_fix;
  always_comb begin
    neg1    = signed_div_i & opdata1_i[WIDTH-1];
    neg2    = signed_div_i & opdata2_i[WIDTH-1];
    mag1    = neg1 ? -opdata1_i : opdata1_i;
    mag2    = neg2 ? -opdata2_i : opdata2_i;
    // next dividend bit enters the partial remainder, then a trial subtract
    shifted = {rem, dvd[WIDTH-1]};
    trial   = shifted - {1'b0, dvs};
    qbit    = ~trial[WIDTH];
    rem_n   = qbit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    quo_n   = {dvd[WIDTH-2:0], qbit};
    quo_fix = neg_q ? -quo_n : quo_n;
    rem_fix = neg_r ? -rem_n : rem_n;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= FREE;
      cnt      <= '0;
      rem      <= '0;
      dvd      <= '0;
      dvs      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      result_o <= '0;
      ready_o  <= 1'b0;
    end else begin
      case (state)
        FREE: begin
          cnt      <= '0;
          result_o <= '0;
          ready_o  <= 1'b0;
          if (start_i && !annul_i) begin
            state <= (opdata2_i == '0) ? BYZERO : ON;
            rem   <= '0;
            dvd   <= mag1;
            dvs   <= mag2;
            neg_q <= neg1 ^ neg2;
            neg_r <= neg1;
          end
        end
        // zero divisor waits two edges so its latency is E2
        BYZERO: begin
          if (annul_i) begin
            state <= FREE;
            cnt   <= '0;
          end else if (cnt == CW'(1)) begin
            state    <= END;
            cnt      <= '0;
            result_o <= '0;
            ready_o  <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ON: begin
          if (annul_i) begin
            state <= FREE;
            cnt   <= '0;
          end else begin
            rem <= rem_n;
            dvd <= quo_n;
            cnt <= cnt + CW'(1);
            if (cnt == CW'(WIDTH - 1)) begin
              state    <= END;
              cnt      <= '0;
              result_o <= {rem_fix, quo_fix};
              ready_o  <= 1'b1;
            end
          end
        end
        END: begin
          if (!start_i || annul_i) begin
            state    <= FREE;
            result_o <= '0;
            ready_o  <= 1'b0;
          end
        end
        default: state <= FREE;
      endcase
    end
  end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed self-checking bench for div_unit (WIDTH=32).
module tb_div_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        signed_div = 1'b0;
  logic [31:0] op1 = '0;
  logic [31:0] op2 = '0;
  logic        start = 1'b0;
  logic        annul = 1'b0;
  logic [63:0] result;
  logic        ready;
  int          checks = 0;
  int          errors = 0;
  div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .signed_div_i(signed_div), .opdata1_i(op1), .opdata2_i(op2),
    .start_i(start), .annul_i(annul), .result_o(result), .ready_o(ready)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // inputs change at negedge; the following posedge is E0
  task automatic run_div(input string tag, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input int lat, input bit hold);
    @(negedge clk);
    signed_div = sgn;
    op1 = a;
    op2 = b;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    op1 = $urandom;
    op2 = $urandom;
    signed_div = ~sgn;
    if (!hold) start = 1'b0;
    for (int i = 1; i <= lat; i++) begin
      @(posedge clk);
      #1;
      if (i == lat - 1) chk({tag, " early ready"}, 64'(ready), 64'd0);
    end
    chk({tag, " ready"}, 64'(ready), 64'd1);
    chk({tag, " result"}, result, exp);
    if (hold) begin
      repeat (3) @(posedge clk);
      #1;
      chk({tag, " hold ready"}, 64'(ready), 64'd1);
      chk({tag, " hold result"}, result, exp);
      @(negedge clk);
      start = 1'b0;
    end
    @(posedge clk);
    #1;
    chk({tag, " drop ready"}, 64'(ready), 64'd0);
    chk({tag, " drop result"}, result, 64'd0);
  endtask
  initial begin
    bit seen;
    #12;
    chk("reset ready", 64'(ready), 64'd0);
    chk("reset result", result, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    run_div("u100/7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 32, 1'b1);
    run_div("s-7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 32, 1'b1);
    run_div("s7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD}, 32, 1'b1);
    run_div("s-100/7", 1'b1, 32'hFFFF_FF9C, 32'd7, {32'hFFFF_FFFE, 32'hFFFF_FFF2}, 32, 1'b1);
    run_div("s-8/-3", 1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFFD, {32'hFFFF_FFFE, 32'd2}, 32, 1'b1);
    run_div("div0", 1'b0, 32'd1234, 32'd0, 64'd0, 2, 1'b1);
    run_div("sMIN/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 32, 1'b1);
    run_div("uMIN/-1", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, {32'h8000_0000, 32'd0}, 32, 1'b1);
    run_div("u start low", 1'b0, 32'hFFFF_FFFF, 32'h10, {32'hF, 32'h0FFF_FFFF}, 32, 1'b0);
    // annul while ON: sampled at E10
    @(negedge clk);
    signed_div = 1'b0;
    op1 = 32'd500;
    op2 = 32'd3;
    start = 1'b1;
    repeat (10) @(negedge clk);
    annul = 1'b1;
    start = 1'b0;
    @(negedge clk);
    annul = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (ready || result != 64'd0) seen = 1'b1;
    end
    chk("annul no ready", 64'(seen), 64'd0);
    run_div("u1000/10", 1'b0, 32'd1000, 32'd10, {32'd0, 32'd100}, 32, 1'b1);
    // annul and start together in FREE: nothing starts
    @(negedge clk);
    op1 = 32'd9;
    op2 = 32'd3;
    start = 1'b1;
    annul = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 36; i++) begin
      @(posedge clk);
      #1;
      if (ready) seen = 1'b1;
    end
    chk("annul blocks start", 64'(seen), 64'd0);
    @(negedge clk);
    start = 1'b0;
    annul = 1'b0;
    // async reset mid-ON at E15
    @(negedge clk);
    op1 = 32'd77;
    op2 = 32'd5;
    start = 1'b1;
    repeat (16) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst midON ready", 64'(ready), 64'd0);
    chk("rst midON result", result, 64'd0);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    // async reset while holding a result in END
    run_div("u77/5", 1'b0, 32'd77, 32'd5, {32'd2, 32'd15}, 32, 1'b1);
    @(negedge clk);
    op1 = 32'd50;
    op2 = 32'd8;
    start = 1'b1;
    repeat (34) @(negedge clk);
    chk("pre rst ready", 64'(ready), 64'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("rst END ready", 64'(ready), 64'd0);
    chk("rst END result", result, 64'd0);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    run_div("u100/7 again", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 32, 1'b1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
